// File: rtl/match_scoreboard.sv
// ---------------------------------------------------------------------------
// match_scoreboard
//
// Keeps a per-match score for two players and shows both scores on a
// 4-digit, 7-segment display, scanning one digit at a time.
//
// A game result counts once, on the cycle where game_finished first goes
// high. The winning player's BCD score then goes up by one and stops at
// SCORE_MAX. A draw changes neither score. reset_match clears both scores
// and wins over a result arriving on the same edge.
//
// Parameters:
//   REFRESH_DIV : clk cycles each digit stays lit (1..65535)
//   SCORE_MAX   : saturation value of each score, decimal (<= 99)
//
// Ports:
//   clk           : segment / scan clock
//   rst           : asynchronous active-high reset
//   reset_match   : synchronous clear of both scores (level)
//   game_finished : high while the current game is over
//   last_winner   : 0 = player 1, 1 = player 2 (valid with game_finished)
//   game_draw     : finished game was a draw (valid with game_finished)
//   p1_score      : player 1 score, BCD {tens,ones}
//   p2_score      : player 2 score, BCD {tens,ones}
//   seg           : active-low segment cathodes, seg[0]=a .. seg[6]=g
//   an            : active-low digit anodes, an[3] = leftmost digit
// ---------------------------------------------------------------------------
module match_scoreboard #(
  parameter int REFRESH_DIV = 4,
  parameter int SCORE_MAX   = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reset_match,
  input  logic       game_finished,
  input  logic       last_winner,
  input  logic       game_draw,
  output logic [7:0] p1_score,
  output logic [7:0] p2_score,
  output logic [6:0] seg,
  output logic [3:0] an
);

  // Saturation value, held in the same BCD form as the scores.
  localparam logic [7:0] MAX_BCD = {4'(SCORE_MAX / 10), 4'(SCORE_MAX % 10)};
  localparam logic [15:0] CNT_LAST = 16'(REFRESH_DIV - 1);

  logic        finQ;
  logic        scoreEvt;
  logic [15:0] refreshCnt;
  logic [1:0]  scanIdx;
  logic [3:0]  digitSel;
  logic [3:0]  anSel;

  // BCD increment that holds at the saturation value.
  function automatic logic [7:0] bcdInc(input logic [7:0] s);
    if (s == MAX_BCD)
      return s;
    else if (s[3:0] == 4'd9)
      return {s[7:4] + 4'd1, 4'd0};
    else
      return {s[7:4], s[3:0] + 4'd1};
  endfunction

  // Active-low gfedcba decode. Any nibble above 9 is shown as a blank digit.
  function automatic logic [6:0] segDecode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Rising edge of game_finished. game_finished can stay high for a long
  // time, so edge detection is what limits scoring to once per game.
  assign scoreEvt = game_finished & ~finQ;

  // Score registers. finQ keeps following game_finished while reset_match
  // is high. Because of this, a finish held across a match reset does not
  // score again when reset_match is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      finQ     <= 1'b0;
      p1_score <= 8'h00;
      p2_score <= 8'h00;
    end else begin
      finQ <= game_finished;
      if (reset_match) begin
        p1_score <= 8'h00;
        p2_score <= 8'h00;
      end else if (scoreEvt && !game_draw) begin
        if (last_winner)
          p2_score <= bcdInc(p2_score);
        else
          p1_score <= bcdInc(p1_score);
      end
    end
  end

  // Scan timing: each digit stays selected for REFRESH_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refreshCnt <= 16'd0;
      scanIdx    <= 2'd0;
    end else if (refreshCnt == CNT_LAST) begin
      refreshCnt <= 16'd0;
      scanIdx    <= scanIdx + 2'd1;
    end else begin
      refreshCnt <= refreshCnt + 16'd1;
    end
  end

  // Choose the digit and anode for the current scan slot.
  always_comb begin
    digitSel = p1_score[7:4];
    anSel    = 4'b0111;
    case (scanIdx)
      2'd0: begin digitSel = p1_score[7:4]; anSel = 4'b0111; end
      2'd1: begin digitSel = p1_score[3:0]; anSel = 4'b1011; end
      2'd2: begin digitSel = p2_score[7:4]; anSel = 4'b1101; end
      default: begin digitSel = p2_score[3:0]; anSel = 4'b1110; end
    endcase
  end

  // Registered display outputs. These lag the scan index by one cycle, so
  // every digit still stays lit for exactly REFRESH_DIV cycles. The reset
  // values match what index 0 shows for a 00 score.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= 7'b1000000;
      an  <= 4'b0111;
    end else begin
      seg <= segDecode(digitSel);
      an  <= anSel;
    end
  end

endmodule

// File: tb/tb_match_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_match_scoreboard
//
// Random and directed stimulus for match_scoreboard, checked against a
// behavioural model. The model keeps the scores as plain integers and
// works out which display digit is shown from the number of clock edges
// since reset.
// ---------------------------------------------------------------------------
module tb_match_scoreboard;

  localparam int REFRESH_DIV = 4;
  localparam int SCORE_MAX   = 99;

  logic       clk = 1'b0;
  logic       rst;
  logic       reset_match;
  logic       game_finished;
  logic       last_winner;
  logic       game_draw;
  logic [7:0] p1_score;
  logic [7:0] p2_score;
  logic [6:0] seg;
  logic [3:0] an;

  int testsRun  = 0;
  int testsFail = 0;

  // Reference model state
  int p1Model  = 0;
  int p2Model  = 0;
  bit finModel = 1'b0;
  int edgeCnt  = 0;   // clk edges since reset released

  match_scoreboard #(
    .REFRESH_DIV(REFRESH_DIV),
    .SCORE_MAX  (SCORE_MAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .reset_match  (reset_match),
    .game_finished(game_finished),
    .last_winner  (last_winner),
    .game_draw    (game_draw),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .seg          (seg),
    .an           (an)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] toBcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] anOf(input int idx);
    case (idx)
      0: return 4'b0111;
      1: return 4'b1011;
      2: return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  // Display slot shown during the most recent clock interval
  function automatic int shownIdx();
    if (edgeCnt == 0) return 0;
    return ((edgeCnt - 1) / REFRESH_DIV) % 4;
  endfunction

  // One clock cycle: apply inputs, step the model, compare every output
  task automatic step(input bit gf, input bit lw, input bit gd, input bit rm);
    int idx, digit, p1Pre, p2Pre;
    bit evt;
    game_finished = gf;
    last_winner   = lw;
    game_draw     = gd;
    reset_match   = rm;
    // the display registers capture the slot and scores in force before this edge
    idx   = (edgeCnt / REFRESH_DIV) % 4;
    p1Pre = p1Model;
    p2Pre = p2Model;
    @(posedge clk);
    #1;
    edgeCnt++;
    evt = gf && !finModel;
    finModel = gf;
    if (rm) begin
      p1Model = 0;
      p2Model = 0;
    end else if (evt && !gd) begin
      if (lw) p2Model = (p2Model < SCORE_MAX) ? p2Model + 1 : p2Model;
      else    p1Model = (p1Model < SCORE_MAX) ? p1Model + 1 : p1Model;
    end
    case (idx)
      0: digit = p1Pre / 10;
      1: digit = p1Pre % 10;
      2: digit = p2Pre / 10;
      default: digit = p2Pre % 10;
    endcase
    checkVal("p1_score", 32'(p1_score), 32'(toBcd(p1Model)));
    checkVal("p2_score", 32'(p2_score), 32'(toBcd(p2Model)));
    checkVal("an", 32'(an), 32'(anOf(idx)));
    checkVal("seg", 32'(seg), 32'(segOf(digit)));
  endtask

  task automatic pulse(input bit lw, input bit gd);
    step(1'b1, lw, gd, 1'b0);
    step(1'b0, lw, gd, 1'b0);
    $display("[TB] pulse winner=%0d draw=%0d -> p1=%h p2=%h", lw, gd, p1_score, p2_score);
  endtask

  task automatic doReset();
    rst = 1'b1;
    game_finished = 1'b0;
    last_winner   = 1'b0;
    game_draw     = 1'b0;
    reset_match   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_p1", 32'(p1_score), 32'h00);
    checkVal("rst_p2", 32'(p2_score), 32'h00);
    checkVal("rst_an", 32'(an), 32'b0111);
    checkVal("rst_seg", 32'(seg), 32'b1000000);
    @(negedge clk);
    rst = 1'b0;
    p1Model  = 0;
    p2Model  = 0;
    finModel = 1'b0;
    edgeCnt  = 0;
  endtask

  initial begin
    bit found;
    doReset();

    // Idle scan: the anode rotates with REFRESH_DIV cycles per digit
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    $display("[TB] idle scan done");

    // A finish held for 20 cycles scores exactly once
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("held_p1", 32'(p1_score), 32'h01);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    $display("[TB] held finish -> p1=%h p2=%h", p1_score, p2_score);

    // Ten wins for player 2: the ones digit carries into the tens
    for (int i = 0; i < 10; i++) pulse(1'b1, 1'b0);
    checkVal("p2_ten", 32'(p2_score), 32'h10);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Player 1 saturates at 99; a draw changes neither score
    for (int i = 0; i < 100; i++) pulse(1'b0, 1'b0);
    checkVal("p1_sat", 32'(p1_score), 32'h99);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b1);
    checkVal("draw_p1", 32'(p1_score), 32'h99);
    checkVal("draw_p2", 32'(p2_score), 32'h10);

    // reset_match on the same edge as a finish rising edge
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) pulse(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    checkVal("rm_p1", 32'(p1_score), 32'h00);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("rm_hold_p1", 32'(p1_score), 32'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    $display("[TB] reset_match collision -> p1=%h p2=%h", p1_score, p2_score);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 40) == 0));
    end
    $display("[TB] random phase -> p1=%h p2=%h", p1_score, p2_score);

    // Build up scores of 12/34, then reset asynchronously while index 2 is shown
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) pulse(1'b0, 1'b0);
    for (int i = 0; i < 34; i++) pulse(1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 4 * REFRESH_DIV + 2; i++) begin
      if (shownIdx() == 2) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkVal("reach_idx2", 32'(found), 32'd1);
    checkVal("pre_rst_an", 32'(an), 32'b1101);
    checkVal("pre_rst_p2", 32'(p2_score), 32'h34);
    #2;
    rst = 1'b1;
    #1;
    checkVal("async_an", 32'(an), 32'b0111);
    checkVal("async_seg", 32'(seg), 32'b1000000);
    checkVal("async_p1", 32'(p1_score), 32'h00);
    checkVal("async_p2", 32'(p2_score), 32'h00);
    $display("[TB] async reset -> an=%b seg=%b", an, seg);
    @(negedge clk);
    rst = 1'b0;
    p1Model  = 0;
    p2Model  = 0;
    finModel = 1'b0;
    edgeCnt  = 0;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, limit reached");
    $fatal(1, "timeout");
  end

endmodule
